// File: rtl/beat_sequencer.sv
// beat_sequencer: tempo-divided beat counter with play/pause/stop/loop control for a tone/LED decoder.
module beat_sequencer #(
  parameter int BASE_DIV  = 25_000_000,
  parameter int LAST_BEAT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        pause,
  input  logic        stop,
  input  logic        loop,
  input  logic [1:0]  tempo,
  output logic [11:0] ibeatNum,
  output logic        en,
  output logic [1:0]  state,
  output logic        wrap,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} st_t;
  localparam logic [26:0] BASE = 27'(BASE_DIV);
  localparam logic [11:0] LAST = 12'(LAST_BEAT);
  st_t cur, nxt;
  logic [26:0] div_cnt, cnt_nxt, period;
  logic [11:0] beat_nxt;
  logic        wrap_nxt, done_nxt, terminal;
  assign period   = BASE >> tempo;
  assign terminal = div_cnt >= period - 27'd1;
  assign state    = cur;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= IDLE;
      div_cnt  <= '0;
      ibeatNum <= '0;
      en       <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cur      <= nxt;
      div_cnt  <= cnt_nxt;
      ibeatNum <= beat_nxt;
      en       <= nxt == PLAY || nxt == DONE;
      wrap     <= wrap_nxt;
      done     <= done_nxt;
    end
  end
  // stop overrides everything; pause in PLAY beats a coincident terminal count
  always_comb begin
    nxt      = cur;
    cnt_nxt  = div_cnt;
    beat_nxt = ibeatNum;
    wrap_nxt = 1'b0;
    done_nxt = 1'b0;
    if (stop) begin
      nxt      = IDLE;
      cnt_nxt  = '0;
      beat_nxt = '0;
    end else begin
      case (cur)
        IDLE, DONE: if (play) begin
          nxt      = PLAY;
          cnt_nxt  = '0;
          beat_nxt = '0;
        end
        PLAY: if (pause) nxt = PAUSE;
          else if (!terminal) cnt_nxt = div_cnt + 27'd1;
          else begin
            cnt_nxt = '0;
            if (ibeatNum < LAST - 12'd1) beat_nxt = ibeatNum + 12'd1;
            else if (loop) begin
              beat_nxt = '0;
              wrap_nxt = 1'b1;
            end else begin
              nxt      = DONE;
              beat_nxt = LAST;
              done_nxt = 1'b1;
            end
          end
        PAUSE: if (play) nxt = PLAY;
        default: nxt = cur;
      endcase
    end
  end
endmodule
